pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central hazard controller for the 5-stage pipeline: tracks in-flight register writes in a scoreboard and sequences branch handling. Generates the dependency-stall and branch-stall signals consumed by fetch and decode. Also drives the branch redirect (select plus target PC) into fetch once the memory stage resolves a branch. Sits beside decode; all decisions are made on the rising edge of the single pipeline clock.

## Interface
Parameters:
- PC_WIDTH, 16, program counter width
- REG_COUNT, 16, architectural registers; register index width is 4
- RESOLVE_TIMEOUT, 15, maximum cycles in WAIT_RESOLVE before error

Ports:
- I_CLOCK  in  1  pipeline clock, rising edge
- I_LOCK  in  1  reset; asynchronous, active-low
- I_DE_Valid  in  1  decode holds a real instruction (not a FetchStall bubble)
- I_DE_PC  in  PC_WIDTH  PC of the decode instruction
- I_DE_IsBranch  in  1  decode instruction is a branch
- I_DE_Src1 / I_DE_Src2  in  4 each  source register indices
- I_DE_Src1Use / I_DE_Src2Use  in  1 each  source is read
- I_DE_Dest  in  4  destination register index
- I_DE_DestUse  in  1  instruction writes I_DE_Dest
- I_WB_Valid  in  1  writeback retires a register write this cycle
- I_WB_Dest  in  4  register being written back
- I_MEM_BranchResolved  in  1  branch outcome is available (1-cycle pulse)
- I_MEM_BranchTaken  in  1  outcome; valid with I_MEM_BranchResolved
- I_MEM_BranchTarget  in  PC_WIDTH  taken target
- O_Issue  out  1  decode instruction accepted this cycle (combinational)
- O_DepStallSignal  out  1  register dependency stall (combinational)
- O_BranchStallSignal  out  1  fetch must hold (combinational)
- O_BranchAddrSelect  out  1  fetch loads O_BranchPC (registered)
- O_BranchPC  out  PC_WIDTH  redirect address (registered)
- O_HazardError  out  1  sticky protocol or timeout error (registered)

## Operation
Scoreboard:
- busy[REG_COUNT] is cleared on reset.
- A register is effectively busy when busy[r] is set and it is not being written back this cycle (I_WB_Valid with I_WB_Dest==r). The register file is write-before-read.
- O_DepStallSignal = I_DE_Valid & state==IDLE & (effectively-busy Src1 with Src1Use, Src2 with Src2Use, or Dest with DestUse; the Dest check covers WAW).
- O_Issue = I_DE_Valid & state==IDLE & ~O_DepStallSignal.
- On an issue with DestUse, busy[Dest] is set. When a writeback clear and an issue set hit the same register in the same cycle, the set wins.
- I_WB_Valid to a register whose busy bit is clear is ignored and sets O_HazardError.

Branch FSM, states IDLE, WAIT_RESOLVE, REDIRECT:
- IDLE: on O_Issue & I_DE_IsBranch:
  - capture fallthrough = I_DE_PC + 4 (truncated to PC_WIDTH, so it wraps)
  - clear the timeout counter
  - go to WAIT_RESOLVE
- WAIT_RESOLVE: the counter increments each cycle.
  - On I_MEM_BranchResolved: O_BranchPC <= Taken ? Target : fallthrough, and go to REDIRECT.
  - If the counter reaches RESOLVE_TIMEOUT: set O_HazardError, load fallthrough into O_BranchPC, and go to REDIRECT.
  - I_DE_Valid here is ignored and never issues.
- REDIRECT: O_BranchAddrSelect=1 for exactly this cycle; the next state is IDLE. No issue happens in REDIRECT.
- O_BranchStallSignal = (state==IDLE & O_Issue & I_DE_IsBranch) | state==WAIT_RESOLVE. It is deasserted in REDIRECT so fetch consumes the redirect.
- I_MEM_BranchResolved outside WAIT_RESOLVE is ignored and sets O_HazardError.
- O_HazardError is cleared only by reset.

## Timing
- Reset (I_LOCK=0, asynchronous) forces immediately:
  - state=IDLE, busy=0, counter=0, fallthrough=0
  - O_BranchAddrSelect=0, O_BranchPC=0, O_HazardError=0
  - the combinational outputs therefore evaluate to 0
- Reset mid-branch abandons the branch; no redirect is produced.
- Dependency stall has 0-cycle latency, on the same cycle as the decode presentation.
- The earliest re-issue of a dependent instruction is the cycle its producer's writeback is presented.
- Branch sequence:
  - issue at cycle N (branch stall high at N)
  - WAIT_RESOLVE from N+1
  - resolve at cycle M ≥ N+1 gives REDIRECT at M+1, with O_BranchAddrSelect=1 and O_BranchPC valid
  - IDLE at M+2, when the first post-branch instruction may issue
- Timeout: if no resolve arrives, REDIRECT follows N+1+RESOLVE_TIMEOUT.

## Test plan
- Reset mid-WAIT_RESOLVE with busy[3]=1 → all outputs 0 at once, busy cleared, no O_BranchAddrSelect pulse after release.
- Issue Dest=r5, next cycle Src1=r5 → O_DepStallSignal=1 and O_Issue=0 until the I_WB_Valid,Dest=5 cycle, where O_Issue=1 and O_DepStallSignal=0.
- Same-cycle I_WB_Valid,Dest=7 and issue with Dest=7 → busy[7] remains 1; a later read of r7 stalls.
- Branch at PC=0x0010, resolve 3 cycles later with Taken=1, Target=0x0040 → stall high 4 cycles, then one cycle of O_BranchAddrSelect=1 with O_BranchPC=0x0040. Repeat with Taken=0 → O_BranchPC=0x0014.
- Branch at PC=0xFFFC, not taken → O_BranchPC=0x0000 (wrap).
- No resolve after a branch → O_HazardError=1 and redirect to fallthrough at cycle N+16. A stray I_MEM_BranchResolved in IDLE → O_HazardError=1 and the state stays IDLE.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: register scoreboard plus branch stall/redirect
// sequencing for the 5-stage pipeline.
module pipe_hazard_ctrl #(
  parameter int PC_WIDTH        = 16,
  parameter int REG_COUNT       = 16,
  parameter int RESOLVE_TIMEOUT = 15
) (
  input  logic                I_CLOCK,
  input  logic                I_LOCK,
  input  logic                I_DE_Valid,
  input  logic [PC_WIDTH-1:0] I_DE_PC,
  input  logic                I_DE_IsBranch,
  input  logic [3:0]          I_DE_Src1,
  input  logic [3:0]          I_DE_Src2,
  input  logic                I_DE_Src1Use,
  input  logic                I_DE_Src2Use,
  input  logic [3:0]          I_DE_Dest,
  input  logic                I_DE_DestUse,
  input  logic                I_WB_Valid,
  input  logic [3:0]          I_WB_Dest,
  input  logic                I_MEM_BranchResolved,
  input  logic                I_MEM_BranchTaken,
  input  logic [PC_WIDTH-1:0] I_MEM_BranchTarget,
  output logic                O_Issue,
  output logic                O_DepStallSignal,
  output logic                O_BranchStallSignal,
  output logic                O_BranchAddrSelect,
  output logic [PC_WIDTH-1:0] O_BranchPC,
  output logic                O_HazardError
);

  localparam int CW = $clog2(RESOLVE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESOLVE,
    REDIRECT
  } state_t;

  state_t               state;
  state_t               stateNext;
  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busyNext;
  logic [REG_COUNT-1:0] wbMask;
  logic [REG_COUNT-1:0] liveBusy;
  logic [CW-1:0]        cnt;
  logic [PC_WIDTH-1:0]  fallThru;
  logic                 brIssue;
  logic                 timeout;
  logic                 errNow;

  // Write-before-read: a register retiring this cycle is readable now.
  always_comb begin
    wbMask = '0;
    if (I_WB_Valid) wbMask[I_WB_Dest] = 1'b1;
    liveBusy = busy & ~wbMask;
  end

  assign brIssue = O_Issue & I_DE_IsBranch;
  assign timeout = (cnt == CW'(RESOLVE_TIMEOUT - 1));

  always_ff @(posedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (brIssue) stateNext = WAIT_RESOLVE;
      end
      WAIT_RESOLVE: begin
        if (I_MEM_BranchResolved || timeout)
          stateNext = REDIRECT;
      end
      REDIRECT: stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Reset also masks decode so outputs drop to 0 immediately.
  always_comb begin
    O_DepStallSignal    = 1'b0;
    O_Issue             = 1'b0;
    O_BranchStallSignal = 1'b0;
    if (I_LOCK && state == IDLE && I_DE_Valid) begin
      O_DepStallSignal =
          (I_DE_Src1Use & liveBusy[I_DE_Src1])
        | (I_DE_Src2Use & liveBusy[I_DE_Src2])
        | (I_DE_DestUse & liveBusy[I_DE_Dest]);
      O_Issue             = ~O_DepStallSignal;
      O_BranchStallSignal = ~O_DepStallSignal
                          & I_DE_IsBranch;
    end
    if (state == WAIT_RESOLVE)
      O_BranchStallSignal = 1'b1;
  end

  always_comb begin
    busyNext = liveBusy;
    if (O_Issue && I_DE_DestUse)
      busyNext[I_DE_Dest] = 1'b1;
  end

  always_comb begin
    errNow = 1'b0;
    if (I_WB_Valid && !busy[I_WB_Dest])
      errNow = 1'b1;
    if (I_MEM_BranchResolved && state != WAIT_RESOLVE)
      errNow = 1'b1;
    if (state == WAIT_RESOLVE && timeout
        && !I_MEM_BranchResolved)
      errNow = 1'b1;
  end

  always_ff @(posedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      busy               <= '0;
      cnt                <= '0;
      fallThru           <= '0;
      O_BranchAddrSelect <= 1'b0;
      O_BranchPC         <= '0;
      O_HazardError      <= 1'b0;
    end else begin
      busy               <= busyNext;
      O_BranchAddrSelect <= (stateNext == REDIRECT);
      if (errNow) O_HazardError <= 1'b1;
      if (state == IDLE && brIssue) begin
        fallThru <= I_DE_PC + PC_WIDTH'(4);
        cnt      <= '0;
      end else if (state == WAIT_RESOLVE) begin
        cnt <= cnt + CW'(1);
      end
      if (state == WAIT_RESOLVE) begin
        if (I_MEM_BranchResolved)
          O_BranchPC <= I_MEM_BranchTaken
                      ? I_MEM_BranchTarget : fallThru;
        else if (timeout)
          O_BranchPC <= fallThru;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  logic        I_CLOCK = 1'b0;
  logic        I_LOCK;
  logic        I_DE_Valid;
  logic [15:0] I_DE_PC;
  logic        I_DE_IsBranch;
  logic [3:0]  I_DE_Src1;
  logic [3:0]  I_DE_Src2;
  logic        I_DE_Src1Use;
  logic        I_DE_Src2Use;
  logic [3:0]  I_DE_Dest;
  logic        I_DE_DestUse;
  logic        I_WB_Valid;
  logic [3:0]  I_WB_Dest;
  logic        I_MEM_BranchResolved;
  logic        I_MEM_BranchTaken;
  logic [15:0] I_MEM_BranchTarget;
  logic        O_Issue;
  logic        O_DepStallSignal;
  logic        O_BranchStallSignal;
  logic        O_BranchAddrSelect;
  logic [15:0] O_BranchPC;
  logic        O_HazardError;

  int vecs = 0;
  int errs = 0;

  pipe_hazard_ctrl #(
    .PC_WIDTH(16),
    .REG_COUNT(16),
    .RESOLVE_TIMEOUT(15)
  ) dut (
    .I_CLOCK(I_CLOCK),
    .I_LOCK(I_LOCK),
    .I_DE_Valid(I_DE_Valid),
    .I_DE_PC(I_DE_PC),
    .I_DE_IsBranch(I_DE_IsBranch),
    .I_DE_Src1(I_DE_Src1),
    .I_DE_Src2(I_DE_Src2),
    .I_DE_Src1Use(I_DE_Src1Use),
    .I_DE_Src2Use(I_DE_Src2Use),
    .I_DE_Dest(I_DE_Dest),
    .I_DE_DestUse(I_DE_DestUse),
    .I_WB_Valid(I_WB_Valid),
    .I_WB_Dest(I_WB_Dest),
    .I_MEM_BranchResolved(I_MEM_BranchResolved),
    .I_MEM_BranchTaken(I_MEM_BranchTaken),
    .I_MEM_BranchTarget(I_MEM_BranchTarget),
    .O_Issue(O_Issue),
    .O_DepStallSignal(O_DepStallSignal),
    .O_BranchStallSignal(O_BranchStallSignal),
    .O_BranchAddrSelect(O_BranchAddrSelect),
    .O_BranchPC(O_BranchPC),
    .O_HazardError(O_HazardError)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  task automatic clr();
    I_DE_Valid = 0; I_DE_PC = '0; I_DE_IsBranch = 0;
    I_DE_Src1 = '0; I_DE_Src2 = '0;
    I_DE_Src1Use = 0; I_DE_Src2Use = 0;
    I_DE_Dest = '0; I_DE_DestUse = 0;
    I_WB_Valid = 0; I_WB_Dest = '0;
    I_MEM_BranchResolved = 0; I_MEM_BranchTaken = 0;
    I_MEM_BranchTarget = '0;
  endtask

  task automatic cyc();
    @(posedge I_CLOCK);
    #1;
  endtask

  task automatic doReset();
    I_LOCK = 0;
    clr();
    cyc();
    cyc();
    I_LOCK = 1;
  endtask

  task automatic test_reset();
    I_LOCK = 0;
    clr();
    #1;
    vecs++;
    if ({O_Issue, O_DepStallSignal, O_BranchStallSignal,
         O_BranchAddrSelect, O_BranchPC, O_HazardError} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got %b/%b/%b/%b/%h/%b want 0",
        O_Issue, O_DepStallSignal, O_BranchStallSignal,
        O_BranchAddrSelect, O_BranchPC, O_HazardError);
    end
    cyc();
    I_LOCK = 1;
    cyc();
  endtask

  task automatic test_dep_stall();
    clr();
    I_DE_Valid = 1; I_DE_Dest = 5; I_DE_DestUse = 1;
    #1;
    vecs++;
    if ({O_Issue, O_DepStallSignal} !== 2'b10) begin
      errs++;
      $display("FAIL dep_producer issue/dep=%b%b want 10",
        O_Issue, O_DepStallSignal);
    end
    cyc();
    for (int k = 0; k < 3; k++) begin
      clr();
      I_DE_Valid = 1; I_DE_Src1 = 5; I_DE_Src1Use = 1;
      if (k == 2) begin I_WB_Valid = 1; I_WB_Dest = 5; end
      #1;
      vecs++;
      if ({O_Issue, O_DepStallSignal} !==
          ((k == 2) ? 2'b10 : 2'b01)) begin
        errs++;
        $display("FAIL dep_consumer k=%0d issue/dep=%b%b",
          k, O_Issue, O_DepStallSignal);
      end
      cyc();
    end
    clr();
  endtask

  task automatic test_waw_same_cycle();
    clr();
    I_DE_Valid = 1; I_DE_Dest = 7; I_DE_DestUse = 1;
    cyc();
    I_WB_Valid = 1; I_WB_Dest = 7;
    #1;
    vecs++;
    if (O_Issue !== 1'b1) begin
      errs++;
      $display("FAIL waw_reissue issue=%b want 1", O_Issue);
    end
    cyc();
    clr();
    I_DE_Valid = 1; I_DE_Src2 = 7; I_DE_Src2Use = 1;
    #1;
    vecs++;
    if ({O_Issue, O_DepStallSignal} !== 2'b01) begin
      errs++;
      $display("FAIL waw_busy_kept issue/dep=%b%b want 01",
        O_Issue, O_DepStallSignal);
    end
    cyc();
    I_WB_Valid = 1; I_WB_Dest = 7;
    cyc();
    clr();
    #1;
    vecs++;
    if (O_HazardError !== 1'b0) begin
      errs++;
      $display("FAIL waw_no_error err=%b want 0", O_HazardError);
    end
  endtask

  task automatic test_branch(input logic [15:0] pc,
                             input logic taken,
                             input logic [15:0] tgt,
                             input logic [15:0] expPc);
    clr();
    I_DE_Valid = 1; I_DE_PC = pc; I_DE_IsBranch = 1;
    #1;
    vecs++;
    if ({O_Issue, O_BranchStallSignal, O_BranchAddrSelect}
        !== 3'b110) begin
      errs++;
      $display("FAIL br_issue pc=%h iss/bst/sel=%b%b%b want 110",
        pc, O_Issue, O_BranchStallSignal, O_BranchAddrSelect);
    end
    cyc();
    for (int k = 1; k <= 3; k++) begin
      clr();
      I_DE_Valid = 1;
      if (k == 3) begin
        I_MEM_BranchResolved = 1;
        I_MEM_BranchTaken = taken;
        I_MEM_BranchTarget = tgt;
      end
      #1;
      vecs++;
      if ({O_Issue, O_BranchStallSignal, O_BranchAddrSelect}
          !== 3'b010) begin
        errs++;
        $display("FAIL br_wait k=%0d iss/bst/sel=%b%b%b want 010",
          k, O_Issue, O_BranchStallSignal, O_BranchAddrSelect);
      end
      cyc();
    end
    clr();
    I_DE_Valid = 1;
    #1;
    vecs++;
    if ({O_Issue, O_BranchStallSignal, O_BranchAddrSelect}
        !== 3'b001 || O_BranchPC !== expPc) begin
      errs++;
      $display("FAIL br_redirect iss/bst/sel=%b%b%b pc=%h want 001 %h",
        O_Issue, O_BranchStallSignal, O_BranchAddrSelect,
        O_BranchPC, expPc);
    end
    cyc();
    #1;
    vecs++;
    if ({O_Issue, O_BranchAddrSelect, O_HazardError} !== 3'b100) begin
      errs++;
      $display("FAIL br_after iss/sel/err=%b%b%b want 100",
        O_Issue, O_BranchAddrSelect, O_HazardError);
    end
    cyc();
    clr();
  endtask

  task automatic test_reset_mid_branch();
    doReset();
    I_DE_Valid = 1; I_DE_Dest = 3; I_DE_DestUse = 1;
    cyc();
    clr();
    I_DE_Valid = 1; I_DE_PC = 16'h0200; I_DE_IsBranch = 1;
    cyc();
    clr();
    #1;
    vecs++;
    if (O_BranchStallSignal !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_wait bst=%b want 1", O_BranchStallSignal);
    end
    I_LOCK = 0;
    #1;
    vecs++;
    if ({O_Issue, O_DepStallSignal, O_BranchStallSignal,
         O_BranchAddrSelect, O_BranchPC, O_HazardError} !== '0) begin
      errs++;
      $display("FAIL rstmid_outputs bst=%b sel=%b pc=%h err=%b want 0",
        O_BranchStallSignal, O_BranchAddrSelect, O_BranchPC,
        O_HazardError);
    end
    cyc();
    cyc();
    I_LOCK = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vecs++;
      if ({O_BranchStallSignal, O_BranchAddrSelect} !== 2'b00) begin
        errs++;
        $display("FAIL rstmid_no_redirect k=%0d bst/sel=%b%b want 00",
          k, O_BranchStallSignal, O_BranchAddrSelect);
      end
      cyc();
    end
    I_DE_Valid = 1; I_DE_Src1 = 3; I_DE_Src1Use = 1;
    #1;
    vecs++;
    if ({O_Issue, O_DepStallSignal} !== 2'b10) begin
      errs++;
      $display("FAIL rstmid_busy_cleared iss/dep=%b%b want 10",
        O_Issue, O_DepStallSignal);
    end
    cyc();
    clr();
  endtask

  task automatic test_timeout();
    doReset();
    I_DE_Valid = 1; I_DE_PC = 16'h0100; I_DE_IsBranch = 1;
    cyc();
    clr();
    for (int k = 1; k <= 16; k++) begin
      #1;
      vecs++;
      if (O_BranchStallSignal !== (k <= 15) ||
          O_BranchAddrSelect !== (k == 16) ||
          O_HazardError !== (k == 16) ||
          (k == 16 && O_BranchPC !== 16'h0104)) begin
        errs++;
        $display("FAIL timeout k=%0d bst=%b sel=%b err=%b pc=%h",
          k, O_BranchStallSignal, O_BranchAddrSelect,
          O_HazardError, O_BranchPC);
      end
      cyc();
    end
    I_DE_Valid = 1;
    #1;
    vecs++;
    if ({O_Issue, O_BranchAddrSelect, O_HazardError} !== 3'b101) begin
      errs++;
      $display("FAIL timeout_after iss/sel/err=%b%b%b want 101",
        O_Issue, O_BranchAddrSelect, O_HazardError);
    end
    cyc();
    clr();
  endtask

  task automatic test_stray_resolve();
    doReset();
    I_MEM_BranchResolved = 1; I_MEM_BranchTaken = 1;
    I_MEM_BranchTarget = 16'h0aaa;
    cyc();
    clr();
    I_DE_Valid = 1;
    #1;
    vecs++;
    if ({O_Issue, O_BranchStallSignal, O_BranchAddrSelect,
         O_HazardError} !== 4'b1001) begin
      errs++;
      $display("FAIL stray iss/bst/sel/err=%b%b%b%b want 1001",
        O_Issue, O_BranchStallSignal, O_BranchAddrSelect,
        O_HazardError);
    end
    cyc();
    clr();
  endtask

  task automatic test_random();
    bit [15:0]   mBusy;
    int          age;
    bit          redir;
    logic [15:0] mFall;
    logic [15:0] mPc;
    bit          mErr;
    bit          idle, dep, iss, bst, nRedir;
    int          r;
    doReset();
    mBusy = '0; age = -1; redir = 0;
    mFall = '0; mPc = '0; mErr = 0;
    for (int n = 0; n < 600; n++) begin
      clr();
      I_DE_Valid = ($urandom_range(0, 3) != 0);
      I_DE_PC = 16'($urandom);
      I_DE_IsBranch = ($urandom_range(0, 7) == 0);
      I_DE_Src1 = 4'($urandom); I_DE_Src1Use = 1'($urandom);
      I_DE_Src2 = 4'($urandom); I_DE_Src2Use = 1'($urandom);
      I_DE_Dest = 4'($urandom); I_DE_DestUse = 1'($urandom);
      r = $urandom_range(0, 15);
      if (mBusy[r] && $urandom_range(0, 1) == 0) begin
        I_WB_Valid = 1; I_WB_Dest = 4'(r);
      end
      if (age >= 0 && $urandom_range(0, 3) == 0) begin
        I_MEM_BranchResolved = 1;
        I_MEM_BranchTaken = 1'($urandom);
        I_MEM_BranchTarget = 16'($urandom);
      end
      #1;
      idle = (age < 0) && !redir;
      dep = 0;
      if (I_DE_Valid && idle) begin
        if (I_DE_Src1Use && mBusy[I_DE_Src1] &&
            !(I_WB_Valid && I_WB_Dest == I_DE_Src1)) dep = 1;
        if (I_DE_Src2Use && mBusy[I_DE_Src2] &&
            !(I_WB_Valid && I_WB_Dest == I_DE_Src2)) dep = 1;
        if (I_DE_DestUse && mBusy[I_DE_Dest] &&
            !(I_WB_Valid && I_WB_Dest == I_DE_Dest)) dep = 1;
      end
      iss = I_DE_Valid && idle && !dep;
      bst = (iss && I_DE_IsBranch) || (age >= 0);
      vecs++;
      if ({O_Issue, O_DepStallSignal, O_BranchStallSignal,
           O_BranchAddrSelect, O_HazardError} !==
          {iss, dep, bst, redir, mErr} || O_BranchPC !== mPc) begin
        errs++;
        $display("FAIL random n=%0d got %b%b%b%b%b pc=%h want %b%b%b%b%b pc=%h",
          n, O_Issue, O_DepStallSignal, O_BranchStallSignal,
          O_BranchAddrSelect, O_HazardError, O_BranchPC,
          iss, dep, bst, redir, mErr, mPc);
      end
      if (I_WB_Valid) mBusy[I_WB_Dest] = 0;
      if (iss && I_DE_DestUse) mBusy[I_DE_Dest] = 1;
      nRedir = 0;
      if (age >= 0) begin
        if (I_MEM_BranchResolved) begin
          mPc = I_MEM_BranchTaken ? I_MEM_BranchTarget : mFall;
          nRedir = 1; age = -1;
        end else if (age + 1 == 15) begin
          mErr = 1; mPc = mFall; nRedir = 1; age = -1;
        end else begin
          age++;
        end
      end else if (I_MEM_BranchResolved) begin
        mErr = 1;
      end
      if (iss && I_DE_IsBranch) begin
        mFall = I_DE_PC + 16'd4;
        age = 0;
      end
      redir = nRedir;
      cyc();
    end
    clr();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    I_LOCK = 0;
    clr();
    #1;
    test_reset();
    test_dep_stall();
    test_waw_same_cycle();
    test_branch(16'h0010, 1'b1, 16'h0040, 16'h0040);
    test_branch(16'h0010, 1'b0, 16'h0040, 16'h0014);
    test_branch(16'hfffc, 1'b0, 16'h1234, 16'h0000);
    test_reset_mid_branch();
    test_timeout();
    test_stray_resolve();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
